mcac_chan_sched: RTL and testbench

- Frame scheduler that time-shares the single ADPCM encoder core across all TDM channels.
- Each frame, TDMI signals a complete input buffer. The block then walks the channels in order. For each channel it reads the PCM sample from the TDMI buffer, starts the core with that channel's id, waits for done, and writes the code word to the output code buffer.
- Sits between TDMI, the ADPCM core and the TDMO-side code buffer.
- Provides per-channel enable, a done watchdog, and sticky error flags.

---
 rtl/mcac_sched_pkg.sv | 25 ++
 rtl/mcac_chan_sched_if.sv | 41 ++++
 rtl/mcac_sched_wdog.sv | 39 +++
 rtl/mcac_chan_sched.sv | 160 ++++++++++++++++
 tb/tb_mcac_chan_sched.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcac_sched_pkg.sv
// Shared types and default sizing for the MCAC channel scheduler.
package mcac_sched_pkg;

    localparam int CHANNELS_DEF = 32;
    localparam int PCM_W_DEF    = 8;
    localparam int CODE_W_DEF   = 4;
    localparam int TIMEOUT_DEF  = 64;

    // Code word emitted for channels that are disabled or whose core never answered.
    localparam logic [CODE_W_DEF-1:0] IDLE_CODE_DEF = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LAT   = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_WRITE = 3'd5
    } sched_state_t;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcac_chan_sched_if.sv
// Scheduler-side bus bundle: TDMI buffer read port, ADPCM core handshake and
// code-buffer write port.
interface mcac_chan_sched_if
    import mcac_sched_pkg::*;
#(
    parameter int CH_W   = 5,
    parameter int PCM_W  = PCM_W_DEF,
    parameter int CODE_W = CODE_W_DEF
);

    logic              rd_en;
    logic [CH_W-1:0]   rd_addr;
    logic [PCM_W-1:0]  rd_data;

    logic              core_start;
    logic [CH_W-1:0]   core_chan;
    logic [PCM_W-1:0]  core_sample;
    logic              core_done;
    logic [CODE_W-1:0] core_code;

    logic              wr_en;
    logic [CH_W-1:0]   wr_addr;
    logic [CODE_W-1:0] wr_data;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output core_start, core_chan, core_sample,
        input  core_done, core_code,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  core_start, core_chan, core_sample,
        output core_done, core_code,
        input  wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/mcac_sched_wdog.sv
// Core-done watchdog: counts enabled cycles from a clear and flags expiry once
// the count reaches TIMEOUT-1.
module mcac_sched_wdog
    import mcac_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

    // Saturates at the expiry value so a stalled WAIT never wraps back to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mcac_chan_sched.sv
// Frame scheduler: walks every TDM channel once per frame through the shared
// ADPCM encoder core and writes one code word per channel to the code buffer.
module mcac_chan_sched
    import mcac_sched_pkg::*;
#(
    parameter int                 CHANNELS  = CHANNELS_DEF,
    parameter int                 CH_W      = chan_w(CHANNELS),
    parameter int                 PCM_W     = PCM_W_DEF,
    parameter int                 CODE_W    = CODE_W_DEF,
    parameter int                 TIMEOUT   = TIMEOUT_DEF,
    parameter logic [CODE_W-1:0]  IDLE_CODE = CODE_W'(IDLE_CODE_DEF)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_sync,
    input  logic [CHANNELS-1:0] chan_en,
    input  logic                clr_err,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun_err,
    output logic                timeout_err,
    mcac_chan_sched_if.master   bus
);

    sched_state_t      state_q, state_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [CH_W-1:0]   core_chan_q, core_chan_d;
    logic [PCM_W-1:0]  sample_q, sample_d;
    logic [CODE_W-1:0] wr_data_q, wr_data_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic timeout_hit;
    logic overrun_hit;
    logic wd_clr;
    logic wd_en;
    logic wd_expired;
    logic last_chan;
    logic chan_on;

    assign last_chan = (chan_q == CH_W'(CHANNELS - 1));
    assign chan_on   = chan_en[chan_q];

    mcac_sched_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        core_chan_d = core_chan_q;
        sample_d    = sample_q;
        wr_data_d   = wr_data_q;
        timeout_hit = 1'b0;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_sync) begin
                    chan_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (chan_on) begin
                    state_d = ST_LAT;
                end else begin
                    wr_data_d = IDLE_CODE;
                    state_d   = ST_WRITE;
                end
            end
            ST_LAT: begin
                // Buffer data arrives one cycle after the read strobe.
                sample_d    = bus.rd_data;
                core_chan_d = chan_q;
                state_d     = ST_START;
            end
            ST_START: begin
                wd_clr  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done that coincides with expiry still delivers its code.
                if (bus.core_done) begin
                    wr_data_d = bus.core_code;
                    state_d   = ST_WRITE;
                end else if (wd_expired) begin
                    wr_data_d   = IDLE_CODE;
                    timeout_hit = 1'b1;
                    state_d     = ST_WRITE;
                end else begin
                    wd_en = 1'b1;
                end
            end
            ST_WRITE: begin
                if (last_chan) begin
                    chan_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    chan_d  = chan_q + CH_W'(1);
                    state_d = ST_READ;
                end
            end
            default: begin
                chan_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: a fresh event in the same cycle as clr_err keeps the flag set.
    assign overrun_hit = frame_sync && (state_q != ST_IDLE);

    always_comb begin
        overrun_d = overrun_hit || (overrun_q && !clr_err);
        timeout_d = timeout_hit || (timeout_q && !clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            chan_q      <= '0;
            core_chan_q <= '0;
            sample_q    <= '0;
            wr_data_q   <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            core_chan_q <= core_chan_d;
            sample_q    <= sample_d;
            wr_data_q   <= wr_data_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.rd_en       = (state_q == ST_READ) && chan_on;
    assign bus.rd_addr     = chan_q;
    assign bus.core_start  = (state_q == ST_START);
    assign bus.core_chan   = core_chan_q;
    assign bus.core_sample = sample_q;
    assign bus.wr_en       = (state_q == ST_WRITE);
    assign bus.wr_addr     = chan_q;
    assign bus.wr_data     = wr_data_q;

    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = (state_q == ST_WRITE) && last_chan;
    assign overrun_err = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mcac_chan_sched.sv
// Directed bench for mcac_chan_sched: TDMI buffer and ADPCM core models plus
// one task per scenario with hand-computed expectations.
`timescale 1ns/1ps
module tb_mcac_chan_sched;

    localparam int CHANNELS = 32;
    localparam int CH_W     = 5;
    localparam int PCM_W    = 8;
    localparam int CODE_W   = 4;
    localparam int TIMEOUT  = 64;

    logic                clk        = 1'b0;
    logic                reset      = 1'b0;
    logic                frame_sync = 1'b0;
    logic                clr_err    = 1'b0;
    logic [CHANNELS-1:0] chan_en    = '1;
    logic                busy, frame_done, overrun_err, timeout_err;

    logic [PCM_W-1:0]  rd_data_tb = '0;
    logic [CODE_W-1:0] code_tb    = '0;
    logic              model_done = 1'b0;
    logic              spur_done  = 1'b0;
    logic              armed      = 1'b0;
    int                wcnt       = 0;
    int                hang_chan  = -1;
    int                slow_chan  = -1;
    int                slow_delay = 1;

    int checks   = 0;
    int failures = 0;

    int cyc      = 0;
    int wr_total = 0;
    int rd_total = 0;
    int cs_total = 0;
    int fd_total = 0;
    int fd_cyc   = 0;
    logic [CH_W-1:0]   wr_addr_log   [0:511];
    logic [CODE_W-1:0] wr_data_log   [0:511];
    logic [CH_W-1:0]   cs_chan_log   [0:511];
    logic [PCM_W-1:0]  cs_sample_log [0:511];

    int k_base, wr_base, rd_base, cs_base;

    mcac_chan_sched_if #(.CH_W(CH_W), .PCM_W(PCM_W), .CODE_W(CODE_W)) bus ();

    assign bus.rd_data   = rd_data_tb;
    assign bus.core_done = model_done | spur_done;
    assign bus.core_code = code_tb;

    mcac_chan_sched #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W),
        .PCM_W    (PCM_W),
        .CODE_W   (CODE_W),
        .TIMEOUT  (TIMEOUT),
        .IDLE_CODE(4'hF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_sync  (frame_sync),
        .chan_en     (chan_en),
        .clr_err     (clr_err),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun_err (overrun_err),
        .timeout_err (timeout_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PCM_W-1:0] sample_of(input int ch);
        return PCM_W'(ch * 7 + 3);
    endfunction

    // Core model: done on WAIT cycle 1 (or slow_delay for slow_chan), never for hang_chan.
    always @(negedge clk) begin
        model_done = 1'b0;
        if (!reset) begin
            armed = 1'b0;
        end else begin
            if (armed) begin
                wcnt++;
                if (wcnt == ((int'(bus.core_chan) == slow_chan) ? slow_delay : 1)) begin
                    model_done = 1'b1;
                    armed      = 1'b0;
                end
            end
            if (bus.core_start && int'(bus.core_chan) != hang_chan) begin
                armed   = 1'b1;
                wcnt    = 0;
                code_tb = bus.core_chan[3:0];
            end
        end
    end

    // TDMI buffer model: registered read, data valid the cycle after rd_en.
    always @(negedge clk) begin
        if (bus.rd_en) rd_data_tb = sample_of(int'(bus.rd_addr));
    end

    always @(negedge clk) begin
        if (bus.wr_en) begin
            wr_addr_log[wr_total % 512] = bus.wr_addr;
            wr_data_log[wr_total % 512] = bus.wr_data;
            wr_total++;
        end
        if (bus.rd_en) rd_total++;
        if (bus.core_start) begin
            cs_chan_log[cs_total % 512]   = bus.core_chan;
            cs_sample_log[cs_total % 512] = bus.core_sample;
            cs_total++;
        end
        if (frame_done) begin
            fd_total++;
            fd_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Pulses frame_sync and waits (bounded) for frame_done; ncyc is the 1-based
    // cycle of frame_done counted from the first READ, or -1 if it never came.
    task automatic run_frame(output int ncyc);
        int fd0;
        bit seen;
        fd0     = fd_total;
        wr_base = wr_total;
        rd_base = rd_total;
        cs_base = cs_total;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        k_base = cyc;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (fd_total != fd0) seen = 1'b1;
            else tick();
        end
        ncyc = seen ? (fd_cyc - k_base + 1) : -1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({busy, frame_done, overrun_err, timeout_err, bus.rd_en, bus.core_start, bus.wr_en} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000000",
                     {busy, frame_done, overrun_err, timeout_err, bus.rd_en, bus.core_start, bus.wr_en});
        end
        checks++;
        if ({bus.core_chan, bus.core_sample, bus.wr_data, bus.wr_addr, bus.rd_addr} !== '0) begin
            failures++;
            $display("FAIL reset_data got chan=%0d sample=%0d wr_data=%0h wr_addr=%0d exp all 0",
                     bus.core_chan, bus.core_sample, bus.wr_data, bus.wr_addr);
        end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_full_frame();
        int ncyc, idx;
        chan_en = '1;
        run_frame(ncyc);
        checks++;
        if (ncyc != 160) begin
            failures++;
            $display("FAIL full_latency got=%0d exp=160", ncyc);
        end
        checks++;
        if ((wr_total - wr_base) != 32 || (rd_total - rd_base) != 32 || (cs_total - cs_base) != 32) begin
            failures++;
            $display("FAIL full_counts got wr=%0d rd=%0d start=%0d exp 32/32/32",
                     wr_total - wr_base, rd_total - rd_base, cs_total - cs_base);
        end
        for (int i = 0; i < 32; i++) begin
            idx = (wr_base + i) % 512;
            checks++;
            if (wr_addr_log[idx] !== CH_W'(i) || wr_data_log[idx] !== CODE_W'(i)) begin
                failures++;
                $display("FAIL full_write[%0d] got addr=%0d data=%0h exp addr=%0d data=%0h",
                         i, wr_addr_log[idx], wr_data_log[idx], i, i % 16);
            end
            idx = (cs_base + i) % 512;
            checks++;
            if (cs_chan_log[idx] !== CH_W'(i) || cs_sample_log[idx] !== sample_of(i)) begin
                failures++;
                $display("FAIL full_start[%0d] got chan=%0d sample=%0d exp chan=%0d sample=%0d",
                         i, cs_chan_log[idx], cs_sample_log[idx], i, sample_of(i));
            end
        end
        checks++;
        if ({overrun_err, timeout_err, busy} !== 3'b000) begin
            failures++;
            $display("FAIL full_flags got ovr/tmo/busy=%b exp=000", {overrun_err, timeout_err, busy});
        end
    endtask

    task automatic test_partial_enable();
        int ncyc, idx;
        logic [CODE_W-1:0] exp_d;
        chan_en = 32'h0000_FFFF;
        run_frame(ncyc);
        chan_en = '1;
        checks++;
        if (ncyc != 112) begin
            failures++;
            $display("FAIL part_latency got=%0d exp=112", ncyc);
        end
        checks++;
        if ((wr_total - wr_base) != 32 || (rd_total - rd_base) != 16 || (cs_total - cs_base) != 16) begin
            failures++;
            $display("FAIL part_counts got wr=%0d rd=%0d start=%0d exp 32/16/16",
                     wr_total - wr_base, rd_total - rd_base, cs_total - cs_base);
        end
        for (int i = 0; i < 32; i++) begin
            idx   = (wr_base + i) % 512;
            exp_d = (i < 16) ? CODE_W'(i) : 4'hF;
            checks++;
            if (wr_addr_log[idx] !== CH_W'(i) || wr_data_log[idx] !== exp_d) begin
                failures++;
                $display("FAIL part_write[%0d] got addr=%0d data=%0h exp addr=%0d data=%0h",
                         i, wr_addr_log[idx], wr_data_log[idx], i, exp_d);
            end
        end
    endtask

    task automatic test_timeout();
        int ncyc, idx;
        hang_chan = 3;
        run_frame(ncyc);
        hang_chan = -1;
        checks++;
        if (ncyc != 223) begin
            failures++;
            $display("FAIL tmo_latency got=%0d exp=223", ncyc);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_flag_set got=%b exp=1", timeout_err);
        end
        for (int i = 2; i < 5; i++) begin
            idx = (wr_base + i) % 512;
            checks++;
            if (wr_addr_log[idx] !== CH_W'(i) || wr_data_log[idx] !== ((i == 3) ? 4'hF : CODE_W'(i))) begin
                failures++;
                $display("FAIL tmo_write[%0d] got addr=%0d data=%0h exp addr=%0d data=%0h",
                         i, wr_addr_log[idx], wr_data_log[idx], i, (i == 3) ? 15 : i);
            end
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_flag_clear got=%b exp=0", timeout_err);
        end

        // Done on the 64th WAIT cycle coincides with expiry: code kept, no error.
        slow_chan  = 7;
        slow_delay = 64;
        run_frame(ncyc);
        idx = (wr_base + 7) % 512;
        checks++;
        if (ncyc != 223 || timeout_err !== 1'b0 || wr_data_log[idx] !== 4'h7) begin
            failures++;
            $display("FAIL tmo_edge_done got lat=%0d err=%b data=%0h exp lat=223 err=0 data=7",
                     ncyc, timeout_err, wr_data_log[idx]);
        end

        // One cycle later the core is too late: timeout, and its done lands in WRITE.
        slow_delay = 65;
        run_frame(ncyc);
        slow_chan  = -1;
        slow_delay = 1;
        idx = (wr_base + 7) % 512;
        checks++;
        if (ncyc != 223 || timeout_err !== 1'b1 || wr_data_log[idx] !== 4'hF || (wr_total - wr_base) != 32) begin
            failures++;
            $display("FAIL tmo_edge_late got lat=%0d err=%b data=%0h writes=%0d exp lat=223 err=1 data=f writes=32",
                     ncyc, timeout_err, wr_data_log[idx], wr_total - wr_base);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_overrun();
        int fd0, k, idx;
        bit seen;
        fd0     = fd_total;
        wr_base = wr_total;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        k = cyc;
        repeat (40) tick();
        // Mid-frame sync together with clr_err: the set must win.
        frame_sync = 1'b1;
        clr_err    = 1'b1;
        tick();
        frame_sync = 1'b0;
        clr_err    = 1'b0;
        checks++;
        if (overrun_err !== 1'b1) begin
            failures++;
            $display("FAIL ovr_mid_set got=%b exp=1", overrun_err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (overrun_err !== 1'b0) begin
            failures++;
            $display("FAIL ovr_mid_clear got=%b exp=0", overrun_err);
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (frame_done === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL ovr_frame_done_wait got=0 exp=1");
        end
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        checks++;
        if (overrun_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovr_last_write got err=%b busy=%b exp err=1 busy=0", overrun_err, busy);
        end
        repeat (6) tick();
        checks++;
        if (busy !== 1'b0 || (fd_total - fd0) != 1 || (wr_total - wr_base) != 32) begin
            failures++;
            $display("FAIL ovr_no_restart got busy=%b frames=%0d writes=%0d exp busy=0 frames=1 writes=32",
                     busy, fd_total - fd0, wr_total - wr_base);
        end
        checks++;
        if ((fd_cyc - k + 1) != 160) begin
            failures++;
            $display("FAIL ovr_latency got=%0d exp=160", fd_cyc - k + 1);
        end
        for (int i = 0; i < 32; i++) begin
            idx = (wr_base + i) % 512;
            checks++;
            if (wr_addr_log[idx] !== CH_W'(i) || wr_data_log[idx] !== CODE_W'(i)) begin
                failures++;
                $display("FAIL ovr_write[%0d] got addr=%0d data=%0h exp addr=%0d data=%0h",
                         i, wr_addr_log[idx], wr_data_log[idx], i, i % 16);
            end
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int w0, ncyc;
        bit seen;
        w0 = wr_total;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (bus.core_start === 1'b1 && bus.core_chan === 5'd10) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_mid_wait_ch10 got=0 exp=1");
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, frame_done, bus.rd_en, bus.core_start, bus.wr_en} !== 5'b0 ||
            {bus.core_chan, bus.core_sample, bus.wr_data, bus.wr_addr, bus.rd_addr} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got busy=%b chan=%0d sample=%0d wr_data=%0h wr_addr=%0d exp all 0",
                     busy, bus.core_chan, bus.core_sample, bus.wr_data, bus.wr_addr);
        end
        checks++;
        if ((wr_total - w0) != 10) begin
            failures++;
            $display("FAIL rst_mid_writes_before got=%0d exp=10", wr_total - w0);
        end
        repeat (3) tick();
        reset = 1'b1;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0 || (wr_total - w0) != 10) begin
            failures++;
            $display("FAIL rst_mid_abandon got busy=%b writes=%0d exp busy=0 writes=10", busy, wr_total - w0);
        end
        run_frame(ncyc);
        checks++;
        if (ncyc != 160 || wr_addr_log[wr_base % 512] !== 5'd0 || (wr_total - wr_base) != 32) begin
            failures++;
            $display("FAIL rst_mid_restart got lat=%0d first_addr=%0d writes=%0d exp lat=160 first_addr=0 writes=32",
                     ncyc, wr_addr_log[wr_base % 512], wr_total - wr_base);
        end
    endtask

    task automatic test_spurious();
        int w0, fd0, k, idx;
        bit seen;
        w0 = wr_total;
        spur_done = 1'b1;
        tick();
        tick();
        spur_done = 1'b0;
        tick();
        checks++;
        if ((wr_total - w0) != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL spur_idle got writes=%0d busy=%b exp writes=0 busy=0", wr_total - w0, busy);
        end
        fd0     = fd_total;
        wr_base = wr_total;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        k = cyc;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (bus.rd_en === 1'b1 && bus.rd_addr === 5'd5) seen = 1'b1;
            else tick();
        end
        tick();
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        for (int i = 0; i < 400 && fd_total == fd0; i++) tick();
        repeat (2) tick();
        checks++;
        if (!seen || fd_total == fd0 || (fd_cyc - k + 1) != 160 || (wr_total - wr_base) != 32) begin
            failures++;
            $display("FAIL spur_lat_frame got seen=%0d lat=%0d writes=%0d exp seen=1 lat=160 writes=32",
                     seen, fd_cyc - k + 1, wr_total - wr_base);
        end
        for (int i = 0; i < 32; i++) begin
            idx = (wr_base + i) % 512;
            checks++;
            if (wr_addr_log[idx] !== CH_W'(i) || wr_data_log[idx] !== CODE_W'(i)) begin
                failures++;
                $display("FAIL spur_write[%0d] got addr=%0d data=%0h exp addr=%0d data=%0h",
                         i, wr_addr_log[idx], wr_data_log[idx], i, i % 16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_partial_enable();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        test_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
